miss_handler: RTL and testbench

MISS_HANDLER -- requirements
Module: miss_handler

---
 rtl/miss_handler.sv | 159 +++++++++++++++
 tb/tb_miss_handler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/miss_handler.sv
`default_nettype none
// ============================================================================
// miss_handler : blocking-cache miss sequencer (victim write-back, line fill)
// Revision     : 1.0
// ============================================================================
module miss_handler #(
  parameter int LINE_WORDS = 4,
  parameter int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  input  logic              hit,
  input  logic              victim_dirty,
  input  logic [31:0]       victim_addr,
  input  logic              stop,
  output logic              delay,
  output logic              busy,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [BEAT_W-1:0] beat,
  output logic              fill_we,
  output logic              tag_we,
  output logic              done
);

  localparam int OFF    = $clog2(LINE_WORDS) + 2;
  localparam int LINE_W = 32 - OFF;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WB_ISSUE   = 3'd1;
  localparam logic [2:0] S_WB_WAIT    = 3'd2;
  localparam logic [2:0] S_WB_XFER    = 3'd3;
  localparam logic [2:0] S_FILL_ISSUE = 3'd4;
  localparam logic [2:0] S_FILL_WAIT  = 3'd5;
  localparam logic [2:0] S_FILL_XFER  = 3'd6;
  localparam logic [2:0] S_FINISH     = 3'd7;

  logic [2:0]        state_q,       state_d;
  logic [BEAT_W-1:0] beat_q,        beat_d;
  logic [LINE_W-1:0] fill_line_q,   fill_line_d;
  logic [LINE_W-1:0] victim_line_q, victim_line_d;

  logic [31:0] w_fill_base;
  logic [31:0] w_victim_base;
  logic [31:0] w_beat_off;
  logic        w_unused;

  assign w_fill_base   = {fill_line_q,   {OFF{1'b0}}};
  assign w_victim_base = {victim_line_q, {OFF{1'b0}}};
  assign w_beat_off    = {{(30-BEAT_W){1'b0}}, beat_q, 2'b00};
  // Byte offsets within the line carry no information for a whole-line miss.
  assign w_unused      = ^{req_addr[OFF-1:0], victim_addr[OFF-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      fill_line_q   <= '0;
      victim_line_q <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      fill_line_q   <= fill_line_d;
      victim_line_q <= victim_line_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    fill_line_d   = fill_line_q;
    victim_line_d = victim_line_q;
    if (!stall) begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && !hit) begin
            fill_line_d   = req_addr[31:OFF];
            victim_line_d = victim_addr[31:OFF];
            state_d       = victim_dirty ? S_WB_ISSUE : S_FILL_ISSUE;
          end
        end
        S_WB_ISSUE:   if (!stop) state_d = S_WB_WAIT;
        S_FILL_ISSUE: if (!stop) state_d = S_FILL_WAIT;
        S_WB_WAIT: begin
          if (!stop) begin
            state_d = S_WB_XFER;
            beat_d  = '0;
          end
        end
        S_FILL_WAIT: begin
          if (!stop) begin
            state_d = S_FILL_XFER;
            beat_d  = '0;
          end
        end
        S_WB_XFER: begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_FILL_ISSUE;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
        S_FILL_XFER: begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_FINISH;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Every strobe is qualified by !stall so a frozen pipeline never sees a repeat.
  always_comb begin
    busy     = 1'b1;
    delay    = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    fill_we  = 1'b0;
    tag_we   = 1'b0;
    done     = 1'b0;
    mem_addr = 32'h0;
    beat     = '0;
    case (state_q)
      S_IDLE: busy = req_valid & ~hit;
      S_WB_ISSUE, S_FILL_ISSUE: delay = ~stall & ~stop;
      S_WB_XFER: begin
        mem_we   = ~stall;
        mem_addr = w_victim_base | w_beat_off;
        beat     = beat_q;
      end
      S_FILL_XFER: begin
        mem_re   = ~stall;
        fill_we  = ~stall;
        mem_addr = w_fill_base | w_beat_off;
        beat     = beat_q;
      end
      S_FINISH: begin
        tag_we   = ~stall;
        done     = ~stall;
        mem_addr = w_fill_base;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_miss_handler.sv
`default_nettype none
// ============================================================================
// tb_miss_handler : directed timeline checks plus randomized scoreboard run
// Revision        : 1.0
// ============================================================================
module tb_miss_handler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, req_valid, hit, victim_dirty, stop;
  logic [31:0] req_addr, victim_addr;
  logic        delay, busy, mem_we, mem_re, fill_we, tag_we, done;
  logic [31:0] mem_addr;
  logic [1:0]  beat;

  logic        req_valid1;
  logic [31:0] req_addr1;
  logic        delay1, busy1, mem_we1, mem_re1, fill_we1, tag_we1, done1;
  logic [31:0] mem_addr1;
  logic        beat1;

  logic [6:0]  w_obs, w_obs1;
  assign w_obs  = {busy,  delay,  mem_we,  mem_re,  fill_we,  tag_we,  done};
  assign w_obs1 = {busy1, delay1, mem_we1, mem_re1, fill_we1, tag_we1, done1};

  miss_handler #(.LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid),
    .req_addr(req_addr), .hit(hit), .victim_dirty(victim_dirty),
    .victim_addr(victim_addr), .stop(stop), .delay(delay), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .beat(beat),
    .fill_we(fill_we), .tag_we(tag_we), .done(done)
  );

  miss_handler #(.LINE_WORDS(1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid1),
    .req_addr(req_addr1), .hit(hit), .victim_dirty(victim_dirty),
    .victim_addr(victim_addr), .stop(stop), .delay(delay1), .busy(busy1),
    .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_re(mem_re1), .beat(beat1),
    .fill_we(fill_we1), .tag_we(tag_we1), .done(done1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int dcnt  = 0;
  logic lat_rand = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Delayer model: a delay pulse raises stop for the latency window that follows.
  task automatic to_next();
    @(posedge clk);
    #1;
    stop = (dcnt != 0);
    if (dcnt != 0) dcnt--;
  endtask

  task automatic to_sample();
    @(negedge clk);
    if (delay || delay1) dcnt = lat_rand ? int'($urandom_range(1, 9)) : 9;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      to_next();
      reset = 1'b1; stall = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0; hit = 1'b0;
      to_sample();
    end
  endtask

  // Miss on 0x1234 (victim 0x8030); expectations follow the documented timeline.
  task automatic directed(input string nm, input logic dirty, input int stall_from,
                          input int rst_at, input int ncyc);
    int F, D, sh;
    logic alive;
    logic [6:0]  ev;
    logic [31:0] ea;
    logic [1:0]  eb;
    F  = dirty ? 27 : 12;
    sh = (stall_from >= 0) ? 3 : 0;
    D  = F + 4 + sh;
    for (int c = 0; c < ncyc; c++) begin
      to_next();
      reset        = (c != rst_at);
      stall        = (stall_from >= 0) && (c >= stall_from) && (c < stall_from + 3);
      req_valid    = (c == 0);
      hit          = 1'b0;
      req_addr     = 32'h0000_1234;
      victim_addr  = 32'h0000_8030;
      victim_dirty = dirty;
      to_sample();
      alive = (rst_at < 0) || (c < rst_at);
      ev = '0; ea = '0; eb = '0;
      if (alive) begin
        ev[6] = (c <= D);
        ev[5] = (c == 1) || (dirty && c == 16);
        if (dirty && c >= 12 && c <= 15) begin
          ev[4] = 1'b1;
          ea    = 32'h8030 + 32'(4 * (c - 12));
          eb    = 2'(c - 12);
        end
        for (int k = 0; k < 4; k++) begin
          if (c == F + k + ((k >= 2) ? sh : 0)) begin
            ev[3] = 1'b1; ev[2] = 1'b1;
            ea    = 32'h1230 + 32'(4 * k);
            eb    = 2'(k);
          end
        end
        if (stall) begin
          ea = 32'h1238;
          eb = 2'd2;
        end
        if (c == D) begin
          ev[1] = 1'b1; ev[0] = 1'b1;
          ea    = 32'h1230;
        end
      end
      check_eq({nm, "/strobes"}, 64'(w_obs), 64'(ev));
      check_eq({nm, "/addr"}, 64'(mem_addr), 64'(ea));
      check_eq({nm, "/beat"}, 64'(beat), 64'(eb));
    end
  endtask

  logic        outstanding;
  int          age;
  logic [32:0] q[$];
  logic [32:0] exp_x;

  initial begin
    reset = 1'b0; stall = 1'b0; req_valid = 1'b1; hit = 1'b0; victim_dirty = 1'b0;
    req_addr = 32'h0; victim_addr = 32'h0; stop = 1'b0;
    req_valid1 = 1'b0; req_addr1 = 32'h0;

    // Reset state: strobes low, busy still reflects the presented miss.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst/miss_presented", {w_obs, mem_addr, beat}, {7'b100_0000, 32'h0, 2'b0});
    req_valid = 1'b0;
    #1;
    check_eq("rst/quiet", {w_obs, mem_addr, beat}, 41'h0);
    check_eq("rst/quiet1", {w_obs1, mem_addr1, beat1}, 40'h0);
    idle(3);

    directed("clean", 1'b0, -1, -1, 20);
    idle(12);
    directed("dirty", 1'b1, -1, -1, 34);
    idle(12);
    directed("stall", 1'b0, 14, -1, 22);
    idle(12);
    directed("reset", 1'b0, -1, 5, 25);
    idle(12);

    // Hits never start a miss.
    for (int c = 0; c < 20; c++) begin
      to_next();
      req_valid = 1'b1; hit = 1'b1; req_addr = $urandom; victim_addr = $urandom;
      victim_dirty = 1'($urandom_range(0, 1));
      to_sample();
      check_eq("hit/quiet", {w_obs, mem_addr, beat}, 41'h0);
    end
    idle(2);

    // Single-word lines: one fill beat, done on the following cycle.
    for (int c = 0; c < 16; c++) begin
      to_next();
      reset = 1'b1; stall = 1'b0; req_valid = 1'b0; hit = 1'b0; victim_dirty = 1'b0;
      req_valid1 = (c == 0); req_addr1 = 32'h0000_0040; victim_addr = 32'h0;
      to_sample();
      check_eq("lw1/strobes", 64'(w_obs1),
               64'({(c <= 13), (c == 1), 1'b0, (c == 12), (c == 12), (c == 13), (c == 13)}));
      check_eq("lw1/addr", 64'(mem_addr1), (c == 12 || c == 13) ? 64'h40 : 64'h0);
      check_eq("lw1/beat", 64'(beat1), 64'h0);
    end
    idle(12);

    // Randomized run against a transaction-level scoreboard.
    lat_rand    = 1'b1;
    outstanding = 1'b0;
    age         = 0;
    for (int c = 0; c < 4000; c++) begin
      to_next();
      reset        = 1'b1;
      stall        = ($urandom_range(0, 4) == 0);
      req_valid    = 1'($urandom_range(0, 1));
      hit          = ($urandom_range(0, 2) == 0);
      req_addr     = $urandom;
      victim_addr  = $urandom;
      victim_dirty = 1'($urandom_range(0, 1));
      to_sample();
      if (stall) check_eq("rnd/gated", {delay, mem_we, mem_re, fill_we, tag_we, done}, 6'h0);
      check_eq("rnd/fill_we", fill_we, mem_re);
      check_eq("rnd/tag_we", tag_we, done);
      if (!outstanding) begin
        check_eq("rnd/idle", {w_obs, mem_addr, beat}, {req_valid & ~hit, 6'b0, 32'h0, 2'b0});
        if (req_valid && !hit && !stall) begin
          outstanding = 1'b1;
          age = 0;
          if (victim_dirty)
            for (int k = 0; k < 4; k++) q.push_back({1'b1, (victim_addr & ~32'hF) + 32'(4 * k)});
          for (int k = 0; k < 4; k++) q.push_back({1'b0, (req_addr & ~32'hF) + 32'(4 * k)});
        end
      end else begin
        age++;
        check_eq("rnd/busy", busy, 1'b1);
        if (mem_we || mem_re) begin
          exp_x = (q.size() > 0) ? q.pop_front() : 33'h1_FFFF_FFFF;
          check_eq("rnd/xfer", {mem_we, mem_addr}, exp_x);
          check_eq("rnd/beat", beat, exp_x[3:2]);
        end
        if (done) begin
          check_eq("rnd/beats_left", q.size(), 0);
          outstanding = 1'b0;
        end else if (age > 600) begin
          check_eq("rnd/timeout", age, 0);
          outstanding = 1'b0;
          q.delete();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
